pentary_to_binary: RTL and testbench



---
 rtl/pentary_to_binary_if.sv | 35 +++
 rtl/pentary_to_binary.sv | 137 +++++++++++++
 tb/tb_pentary_to_binary.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pentary_to_binary_if.sv
// ---------------------------------------------------------------------------
// pentary_to_binary_if
// Handshake bundle between a pentary word producer and the pentary-to-binary
// converter.
//   in_valid/in_ready   : input word handshake (producer -> converter)
//   in_digits           : NUM_DIGITS pentary digits, 3 bits each, digit 0 in [2:0]
//   in_carry            : pentary carry digit, weight 5^NUM_DIGITS
//   out_valid/out_ready : result handshake (converter -> consumer)
//   out_data            : signed two's-complement result
//   out_err             : an illegal digit code was seen in the word
// master = producer/consumer side, slave = converter side.
// ---------------------------------------------------------------------------
interface pentary_to_binary_if #(
  parameter int NUM_DIGITS = 16,
  parameter int OUT_W      = 40
);
  logic                           in_valid;
  logic                           in_ready;
  logic [3*NUM_DIGITS-1:0]        in_digits;
  logic [2:0]                     in_carry;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUT_W-1:0]        out_data;
  logic                           out_err;

  modport master (
    output in_valid, in_digits, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_digits, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/pentary_to_binary.sv
// ---------------------------------------------------------------------------
// pentary_to_binary
// Converts a NUM_DIGITS-digit pentary word plus its carry digit into a signed
// two's-complement value, one digit per clock, MSB (carry) first, using
// acc = acc*5 + digit. Illegal digit codes contribute 0 and flag out_err.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pentary_to_binary_if.slave (valid/ready on input and output)
// ---------------------------------------------------------------------------
module pentary_to_binary #(
  parameter int NUM_DIGITS = 16,
  parameter int OUT_W      = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pentary_to_binary_if.slave    bus
);

  // Smallest signed width holding +/-(5^(nd+1)-1)/2.
  function automatic int min_out_w(input int nd);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i <= nd; i++) p = p * 128'd5;
    p = (p - 128'd1) / 128'd2;
    for (int w = 1; w < 128; w++)
      if ((128'd1 << (w - 1)) > p) return w;
    return 128;
  endfunction

  generate
    if (OUT_W < min_out_w(NUM_DIGITS)) begin : g_out_w_too_small
      $error("pentary_to_binary: OUT_W too small for NUM_DIGITS");
    end
  endgenerate

  localparam int            TOT_DIGITS = NUM_DIGITS + 1;
  localparam int            CNT_W      = $clog2(TOT_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS);

  // Encoding is offset-by-2: code - 2 gives the digit for legal codes.
  function automatic logic signed [2:0] dec_digit(input logic [2:0] code);
    if (code > 3'd4) return 3'sd0;
    return $signed(code - 3'd2);
  endfunction

  function automatic logic is_illegal(input logic [2:0] code);
    return code > 3'd4;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [3*TOT_DIGITS-1:0]   r_shift;
  logic signed [OUT_W-1:0]   r_acc;
  logic                      r_err;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_err;
  logic                      r_out_valid;

  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_release;
  logic [2:0]                w_top;
  logic signed [2:0]         w_dig;
  logic signed [OUT_W-1:0]   w_dig_ext;
  logic signed [OUT_W-1:0]   w_acc_nxt;
  logic                      w_err_nxt;

  assign w_in_ready = (r_state == IDLE) && rst_n;
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_last     = (r_state == CONV) && (r_cnt == LAST_CNT);
  assign w_release  = (r_state == DONE) && bus.out_ready;

  // Digit evaluation: carry sits in the top slot so it is consumed first.
  assign w_top      = r_shift[3*TOT_DIGITS-1 -: 3];
  assign w_dig      = dec_digit(w_top);
  assign w_dig_ext  = {{(OUT_W-3){w_dig[2]}}, w_dig};
  assign w_acc_nxt  = (r_acc <<< 2) + r_acc + w_dig_ext;
  assign w_err_nxt  = r_err | is_illegal(w_top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = CONV;
      CONV:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Capture stage: inputs are only sampled here.
      if (w_accept) begin
        r_shift <= {bus.in_carry, bus.in_digits};
        r_acc   <= '0;
        r_err   <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == CONV) begin
        // Accumulate stage: one digit per clock.
        r_acc   <= w_acc_nxt;
        r_err   <= w_err_nxt;
        r_shift <= r_shift << 3;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          // Result stage: held until the consumer takes it.
          r_out_data  <= w_acc_nxt;
          r_out_err   <= w_err_nxt;
          r_out_valid <= 1'b1;
        end
      end
      if (w_release) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_pentary_to_binary.sv
// ---------------------------------------------------------------------------
// tb_pentary_to_binary
// Directed and randomized stimulus for pentary_to_binary, checked against a
// positional-sum reference model (sum of digit * 5^position).
// ---------------------------------------------------------------------------
module tb_pentary_to_binary;

  localparam int ND = 16;
  localparam int OW = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pentary_to_binary_if #(.NUM_DIGITS(ND), .OUT_W(OW)) bus ();

  pentary_to_binary #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] out_val();
    logic signed [63:0] v;
    v = $signed(bus.out_data);
    return v;
  endfunction

  // Reference: value = sum(dec(d_i) * 5^i) + dec(carry) * 5^ND.
  task automatic ref_model(input logic [3*ND-1:0] dg, input logic [2:0] cy,
                           output logic signed [63:0] v, output logic e);
    longint acc, w;
    int c;
    acc = 0; w = 1; e = 1'b0;
    for (int i = 0; i <= ND; i++) begin
      c = (i == ND) ? int'(cy) : int'(dg[3*i +: 3]);
      if (c > 4) e = 1'b1;
      else       acc = acc + longint'(c - 2) * w;
      w = w * 5;
    end
    v = acc;
  endtask

  function automatic logic [3*ND-1:0] fill(input logic [2:0] c);
    return {ND{c}};
  endfunction

  task automatic scramble();
    bus.in_digits = {$urandom, $urandom};
    bus.in_carry  = 3'($urandom);
  endtask

  // Sends one word; hold > 0 keeps out_ready low that many cycles after
  // out_valid rises, with in_valid held high meanwhile.
  task automatic run_word(input string tag, input logic [3*ND-1:0] dg,
                          input logic [2:0] cy, input int hold);
    logic signed [63:0] ev;
    logic ee;
    int k, lat;
    ref_model(dg, cy, ev, ee);
    @(negedge clk);
    k = 0;
    while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
    check({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'sd1);
    bus.in_valid  = 1'b1;
    bus.in_digits = dg;
    bus.in_carry  = cy;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'sd0);
    bus.in_valid = (hold > 0);
    scramble();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      scramble();
      lat++;
    end
    check({tag, "_latency"}, lat, 17);
    check({tag, "_data"}, out_val(), ev);
    check({tag, "_err"}, 64'(bus.out_err), 64'(ee));
    if (hold > 0) begin
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        check({tag, "_bp_valid"}, 64'(bus.out_valid), 64'sd1);
        check({tag, "_bp_data"}, out_val(), ev);
        check({tag, "_bp_err"}, 64'(bus.out_err), 64'(ee));
        check({tag, "_bp_in_ready"}, 64'(bus.in_ready), 64'sd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'sd0);
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'sd1);
    check({tag, "_data_held"}, out_val(), ev);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'sd0);
    check({tag, "_data"}, out_val(), 64'sd0);
    check({tag, "_err"}, 64'(bus.out_err), 64'sd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'sd0);
  endtask

  initial begin
    logic [3*ND-1:0] dg;
    logic [2:0] cy;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.in_digits = '0;
    bus.in_carry  = 3'b010;
    bus.out_ready = 1'b1;

    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_word("zero", fill(3'b010), 3'b010, 0);

    dg = fill(3'b010); dg[2:0] = 3'b011; dg[5:3] = 3'b001;
    run_word("minus4", dg, 3'b010, 0);
    check("minus4_const", out_val(), -64'sd4);

    run_word("max_c1", fill(3'b100), 3'b011, 0);
    check("max_c1_const", out_val(), 64'sd228881835937);
    run_word("min_c1", fill(3'b000), 3'b001, 0);
    check("min_c1_const", out_val(), -64'sd228881835937);
    run_word("max_c2", fill(3'b100), 3'b100, 0);
    check("max_c2_const", out_val(), 64'sd381469726562);
    run_word("min_c2", fill(3'b000), 3'b000, 0);

    dg = fill(3'b010); dg[17:15] = 3'b111;
    run_word("illegal", dg, 3'b010, 0);
    check("illegal_err", 64'(bus.out_err), 64'sd1);
    dg = fill(3'b010); dg[2:0] = 3'b100;
    run_word("clean_after", dg, 3'b010, 0);
    check("clean_after_err", 64'(bus.out_err), 64'sd0);

    dg = fill(3'b010); dg[2:0] = 3'b011; dg[5:3] = 3'b001;
    run_word("backpressure", dg, 3'b100, 10);
    run_word("after_bp", fill(3'b011), 3'b010, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < ND; i++)
        dg[3*i +: 3] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                   : 3'($urandom_range(0, 4));
      cy = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      run_word("rand", dg, cy, (t % 7 == 3) ? int'($urandom_range(1, 4)) : 0);
    end

    // Abort in the middle of a conversion.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_digits = fill(3'b100);
    bus.in_carry  = 3'b100;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort_now");
    repeat (2) @(negedge clk);
    check_zero("abort_held");
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'sd0);
    check("abort_data_zero", out_val(), 64'sd0);

    dg = fill(3'b010); dg[2:0] = 3'b011; dg[5:3] = 3'b001;
    run_word("post_abort", dg, 3'b010, 0);
    check("post_abort_const", out_val(), -64'sd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
